// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encodings, access size
// codes, default memory window, the latched request record and the
// address-legality check.
package dmem_arbiter_pkg;

    // FSM encodings
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    // Access size codes, shared with the data memory's bit_ctrl port
    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    // Default data-memory window
    localparam logic [31:0] DMEM_BASE_DEFAULT  = 32'h0200_0000;
    localparam int unsigned DMEM_BYTES_DEFAULT = 4096;

    // One request as captured at the accept edge
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
        logic        we;
    } req_t;

    // Number of bytes touched by an access; the illegal code is treated as a
    // word so the range check stays well defined (it is rejected anyway).
    function automatic logic [32:0] size_bytes(input logic [1:0] size);
        logic [32:0] n;
        case (size)
            SIZE_BYTE: n = 33'd1;
            SIZE_HALF: n = 33'd2;
            default:   n = 33'd4;
        endcase
        return n;
    endfunction

    // A request is rejected for an illegal size, a misaligned half/word, or
    // any byte outside [base, limit). Done in 33 bits so addresses near
    // 32'hFFFF_FFFF cannot wrap back into the window.
    function automatic logic access_err(
        input logic [31:0] addr,
        input logic [1:0]  size,
        input logic [32:0] base,
        input logic [32:0] limit
    );
        logic [32:0] last_byte;
        logic        err;
        last_byte = {1'b0, addr} + size_bytes(size) - 33'd1;
        err = 1'b0;
        if (size == SIZE_ILLEGAL)                       err = 1'b1;
        if ((size == SIZE_HALF) && addr[0])             err = 1'b1;
        if ((size == SIZE_WORD) && (addr[1:0] != 2'b00)) err = 1'b1;
        if ({1'b0, addr} < base)                        err = 1'b1;
        if (last_byte >= limit)                         err = 1'b1;
        return err;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-requester round-robin pick. With a single valid requester it wins;
// with both valid, the one that was not granted last wins.
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,   // index of the port granted last
    output logic [1:0] gnt_o           // one-hot grant, 0 when nobody asks
);

    // Select the winner from the valid vector and the last grant
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned and a latch is never inferred.
        gnt_o = 2'b00;
        case (valid_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_grant_i ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter. Requests are accepted in IDLE (round-robin
// between ports), the captured request drives the memory for one ACCESS cycle,
// and a registered one-cycle response is returned to the requesting port as
// the FSM falls back to IDLE. One access every two cycles at best.
// op_mem_sign_ctrl carries the request's unsigned flag: 1 = zero-extend.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter logic [31:0] DMEM_BASE  = DMEM_BASE_DEFAULT,
    parameter int unsigned DMEM_BYTES = DMEM_BYTES_DEFAULT
) (
    input  logic        ip_clk,
    input  logic        ip_rst,

    // Requester 0
    input  logic        ip_req_valid_0,
    output logic        op_req_ready_0,
    input  logic [31:0] ip_req_addr_0,
    input  logic [31:0] ip_req_wdata_0,
    input  logic [1:0]  ip_req_size_0,
    input  logic        ip_req_unsigned_0,
    input  logic        ip_req_we_0,
    output logic        op_rsp_valid_0,
    output logic [31:0] op_rsp_data_0,
    output logic        op_rsp_err_0,

    // Requester 1
    input  logic        ip_req_valid_1,
    output logic        op_req_ready_1,
    input  logic [31:0] ip_req_addr_1,
    input  logic [31:0] ip_req_wdata_1,
    input  logic [1:0]  ip_req_size_1,
    input  logic        ip_req_unsigned_1,
    input  logic        ip_req_we_1,
    output logic        op_rsp_valid_1,
    output logic [31:0] op_rsp_data_1,
    output logic        op_rsp_err_1,

    // Data memory
    output logic [31:0] op_mem_addr,
    output logic [31:0] op_mem_store_data,
    output logic [1:0]  op_mem_bit_ctrl,
    output logic        op_mem_sign_ctrl,
    output logic        op_mem_store_en,
    input  logic [31:0] ip_mem_read_data
);

    localparam logic [32:0] WIN_BASE  = {1'b0, DMEM_BASE};
    localparam logic [32:0] WIN_LIMIT = WIN_BASE + 33'(DMEM_BYTES);

    // State
    logic [0:0]       state_q, state_d;
    logic             last_q, last_d;        // port granted last
    logic             port_q, port_d;        // port being served
    req_t             req_q, req_d;
    logic             err_q, err_d;
    logic [1:0]       rsp_valid_q, rsp_valid_d;
    logic [1:0]       rsp_err_q, rsp_err_d;
    logic [1:0][31:0] rsp_data_q, rsp_data_d;

    // Arbitration
    logic [1:0] valid_vec;
    logic [1:0] gnt;
    logic       idle;
    logic       accept;
    req_t       req_in0, req_in1, req_sel;

    assign valid_vec = {ip_req_valid_1, ip_req_valid_0};

    rr_arb2 u_rr_arb2 (
        .valid_i      (valid_vec),
        .last_grant_i (last_q),
        .gnt_o        (gnt)
    );

    // Ready is offered only in IDLE and is forced low while reset is held
    assign idle           = (state_q == ST_IDLE) && !ip_rst;
    assign op_req_ready_0 = idle && gnt[0];
    assign op_req_ready_1 = idle && gnt[1];
    assign accept         = (op_req_ready_0 && ip_req_valid_0) ||
                            (op_req_ready_1 && ip_req_valid_1);

    assign req_in0 = '{addr: ip_req_addr_0, wdata: ip_req_wdata_0,
                       size: ip_req_size_0, uns: ip_req_unsigned_0,
                       we: ip_req_we_0};
    assign req_in1 = '{addr: ip_req_addr_1, wdata: ip_req_wdata_1,
                       size: ip_req_size_1, uns: ip_req_unsigned_1,
                       we: ip_req_we_1};
    assign req_sel = gnt[1] ? req_in1 : req_in0;

    // Next-state: capture on accept in IDLE, respond and return from ACCESS
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        port_d      = port_q;
        req_d       = req_q;
        err_d       = err_q;
        rsp_valid_d = 2'b00;
        rsp_err_d   = 2'b00;
        rsp_data_d  = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_ACCESS;
                    port_d  = gnt[1];
                    last_d  = gnt[1];
                    req_d   = req_sel;
                    err_d   = access_err(req_sel.addr, req_sel.size,
                                         WIN_BASE, WIN_LIMIT);
                end
            end
            ST_ACCESS: begin
                state_d              = ST_IDLE;
                rsp_valid_d[port_q]  = 1'b1;
                rsp_err_d[port_q]    = err_q;
                rsp_data_d[port_q]   = (!err_q && !req_q.we) ? ip_mem_read_data
                                                             : 32'h0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and response registers
    always_ff @(posedge ip_clk or posedge ip_rst) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values; the captured request is reset
        // too because it drives the memory outputs and must start at 0.
        if (ip_rst) begin
            state_q     <= ST_IDLE;
            last_q      <= 1'b1;
            port_q      <= 1'b0;
            req_q       <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= 2'b00;
            rsp_err_q   <= 2'b00;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            port_q      <= port_d;
            req_q       <= req_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Memory side is driven only during ACCESS; a rejected store never writes
    always_comb begin
        op_mem_addr       = 32'h0;
        op_mem_store_data = 32'h0;
        op_mem_bit_ctrl   = 2'b00;
        op_mem_sign_ctrl  = 1'b0;
        op_mem_store_en   = 1'b0;
        if (state_q == ST_ACCESS) begin
            op_mem_addr       = req_q.addr;
            op_mem_store_data = req_q.wdata;
            op_mem_bit_ctrl   = req_q.size;
            op_mem_sign_ctrl  = req_q.uns;
            op_mem_store_en   = req_q.we && !err_q;
        end
    end

    assign op_rsp_valid_0 = rsp_valid_q[0];
    assign op_rsp_valid_1 = rsp_valid_q[1];
    assign op_rsp_err_0   = rsp_err_q[0];
    assign op_rsp_err_1   = rsp_err_q[1];
    assign op_rsp_data_0  = rsp_data_q[0];
    assign op_rsp_data_1  = rsp_data_q[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small byte-addressed data memory.
module tb_dmem_arbiter;

    localparam logic [31:0] BASE = 32'h0200_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        valid0 = 0, valid1 = 0;
    logic        ready0, ready1;
    logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
    logic [1:0]  size0 = 0, size1 = 0;
    logic        uns0 = 0, uns1 = 0, we0 = 0, we1 = 0;
    logic        rvalid0, rvalid1, rerr0, rerr1;
    logic [31:0] rdata0, rdata1;

    logic [31:0] mem_addr, mem_sdata, mem_rdata;
    logic [1:0]  mem_bits;
    logic        mem_sign, mem_we;

    int total = 0;
    int bad   = 0;
    int store_cnt = 0;
    int rsp_cnt0 = 0, rsp_cnt1 = 0;
    logic both_ready = 1'b0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .ip_clk            (clk),
        .ip_rst            (rst),
        .ip_req_valid_0    (valid0),
        .op_req_ready_0    (ready0),
        .ip_req_addr_0     (addr0),
        .ip_req_wdata_0    (wdata0),
        .ip_req_size_0     (size0),
        .ip_req_unsigned_0 (uns0),
        .ip_req_we_0       (we0),
        .op_rsp_valid_0    (rvalid0),
        .op_rsp_data_0     (rdata0),
        .op_rsp_err_0      (rerr0),
        .ip_req_valid_1    (valid1),
        .op_req_ready_1    (ready1),
        .ip_req_addr_1     (addr1),
        .ip_req_wdata_1    (wdata1),
        .ip_req_size_1     (size1),
        .ip_req_unsigned_1 (uns1),
        .ip_req_we_1       (we1),
        .op_rsp_valid_1    (rvalid1),
        .op_rsp_data_1     (rdata1),
        .op_rsp_err_1      (rerr1),
        .op_mem_addr       (mem_addr),
        .op_mem_store_data (mem_sdata),
        .op_mem_bit_ctrl   (mem_bits),
        .op_mem_sign_ctrl  (mem_sign),
        .op_mem_store_en   (mem_we),
        .ip_mem_read_data  (mem_rdata)
    );

    // Data memory: combinational read, write on the rising edge
    logic [7:0]  mem [4096] = '{default: 8'h00};
    logic [11:0] moff;
    assign moff = 12'(mem_addr - BASE);

    always_comb begin
        mem_rdata = 32'h0;
        case (mem_bits)
            2'b00: mem_rdata = mem_sign ? {24'h0, mem[moff]}
                                        : {{24{mem[moff][7]}}, mem[moff]};
            2'b01: mem_rdata = mem_sign ? {16'h0, mem[moff + 12'd1], mem[moff]}
                                        : {{16{mem[moff + 12'd1][7]}}, mem[moff + 12'd1], mem[moff]};
            2'b10: mem_rdata = {mem[moff + 12'd3], mem[moff + 12'd2],
                                mem[moff + 12'd1], mem[moff]};
            default: mem_rdata = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        if (mem_we) begin
            store_cnt++;
            mem[moff] <= mem_sdata[7:0];
            if (mem_bits != 2'b00) mem[moff + 12'd1] <= mem_sdata[15:8];
            if (mem_bits == 2'b10) begin
                mem[moff + 12'd2] <= mem_sdata[23:16];
                mem[moff + 12'd3] <= mem_sdata[31:24];
            end
        end
        if (rvalid0) rsp_cnt0++;
        if (rvalid1) rsp_cnt1++;
    end

    always @(negedge clk) if (ready0 && ready1) both_ready = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit p, input logic v, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] s, input logic u, input logic w);
        if (!p) begin valid0 = v; addr0 = a; wdata0 = d; size0 = s; uns0 = u; we0 = w; end
        else    begin valid1 = v; addr1 = a; wdata1 = d; size1 = s; uns1 = u; we1 = w; end
    endtask

    function automatic logic rdy(input bit p);
        return p ? ready1 : ready0;
    endfunction

    // One request on port p, with its response fully checked
    task automatic issue(input string tag, input bit p, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] s, input logic u, input logic w,
                         input logic exp_err, input logic [31:0] exp_data);
        int n;
        int st0;
        logic got;
        st0 = store_cnt;
        @(negedge clk);
        drive(p, 1'b1, a, d, s, u, w);
        #1;
        n = 0;
        while (!rdy(p) && n < 20) begin @(negedge clk); #1; n++; end
        if (!rdy(p)) begin
            check({tag, "_ready"}, {31'h0, rdy(p)}, 32'h1);
            drive(p, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0);
            return;
        end
        @(posedge clk);
        @(negedge clk);
        // scramble fields: only the accept-edge values may be used
        drive(p, 1'b0, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 2'b11, 1'b1, 1'b1);
        n = 1;
        got = p ? rvalid1 : rvalid0;
        while (!got && n < 10) begin
            @(negedge clk);
            n++;
            got = p ? rvalid1 : rvalid0;
        end
        check({tag, "_latency"}, n, 2);
        check({tag, "_err"},  {31'h0, p ? rerr1 : rerr0}, {31'h0, exp_err});
        check({tag, "_data"}, p ? rdata1 : rdata0, exp_data);
        check({tag, "_other_quiet"}, {p ? rvalid0 : rvalid1, p ? rerr0 : rerr1} | (p ? rdata0 : rdata1), 32'h0);
        @(negedge clk);
        check({tag, "_strobe_1cyc"}, {31'h0, p ? rvalid1 : rvalid0}, 32'h0);
        check({tag, "_stores"}, store_cnt - st0, (w && !exp_err) ? 1 : 0);
    endtask

    initial begin
        int grants;
        int n;
        logic [1:0] order [4];
        int st0, r0, r1;

        // Reset state with both requesters asking
        drive(0, 1'b1, BASE, 32'h1, 2'b10, 1'b0, 1'b1);
        drive(1, 1'b1, BASE, 32'h2, 2'b10, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check("rst_ready", {ready1, ready0}, 2'b00);
        check("rst_mem_we", {31'h0, mem_we}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_rsp", {rvalid1, rvalid0, rerr1, rerr0} | rdata0 | rdata1, 32'h0);
        drive(0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0);
        drive(1, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0);
        rst = 1'b0;

        // Both valid every cycle: grants must alternate starting at port 0
        @(negedge clk);
        drive(0, 1'b1, BASE + 32'h40, 32'h0, 2'b10, 1'b0, 1'b0);
        drive(1, 1'b1, BASE + 32'h44, 32'h0, 2'b10, 1'b0, 1'b0);
        grants = 0;
        n = 0;
        while (grants < 4 && n < 40) begin
            #1;
            if (ready0) begin order[grants] = 2'd0; grants++; end
            else if (ready1) begin order[grants] = 2'd1; grants++; end
            n++;
            if (grants < 4) @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0);
        drive(1, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("rr_grants", grants, 4);
        check("rr_order", {24'h0, order[0], order[1], order[2], order[3]}, {24'h0, 8'b00_01_00_01});
        check("rr_no_dual_ready", {31'h0, both_ready}, 32'h0);

        // Word store from port 0, memory side checked mid-ACCESS
        st0 = store_cnt;
        @(negedge clk);
        drive(0, 1'b1, BASE + 32'h10, 32'h1234_5678, 2'b10, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0);
        check("st_mem_addr", mem_addr, BASE + 32'h10);
        check("st_mem_data", mem_sdata, 32'h1234_5678);
        check("st_mem_bits", {30'h0, mem_bits}, 32'h2);
        check("st_mem_we", {31'h0, mem_we}, 32'h1);
        @(negedge clk);
        check("st_rsp_valid0", {31'h0, rvalid0}, 32'h1);
        check("st_rsp_err0", {31'h0, rerr0}, 32'h0);
        check("st_mem_idle", mem_addr | {31'h0, mem_we}, 32'h0);
        check("st_store_pulses", store_cnt - st0, 1);

        // Port 1 loads it back
        issue("ld1_word", 1, BASE + 32'h10, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0, 32'h1234_5678);

        // Byte stores and signed/unsigned byte loads
        issue("sb_5d", 0, BASE, 32'h08EF_965D, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0);
        issue("lb_5d", 0, BASE, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0000_005D);
        issue("lbu_5d", 0, BASE, 32'h0, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0000_005D);
        issue("sb_b8", 0, BASE, 32'hD9A4_38B8, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0);
        issue("lb_b8", 0, BASE, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFB8);
        issue("lbu_b8", 1, BASE, 32'h0, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0000_00B8);

        // Rejected accesses
        issue("err_half_odd", 0, BASE + 32'h3, 32'h0, 2'b01, 1'b0, 1'b0, 1'b1, 32'h0);
        issue("err_word_end", 1, BASE + 32'hFFE, 32'h0, 2'b10, 1'b0, 1'b0, 1'b1, 32'h0);
        issue("err_st_below", 0, 32'h01FF_FFFC, 32'hCAFE_F00D, 2'b10, 1'b0, 1'b1, 1'b1, 32'h0);
        issue("err_size3", 1, BASE + 32'h10, 32'hCAFE_F00D, 2'b11, 1'b0, 1'b1, 1'b1, 32'h0);
        issue("err_wrap", 0, 32'hFFFF_FFFC, 32'h0, 2'b10, 1'b0, 1'b0, 1'b1, 32'h0);
        issue("ok_last_word", 1, BASE + 32'hFFC, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0, 32'h0);
        issue("ok_half_sx", 0, BASE + 32'h12, 32'h0, 2'b01, 1'b0, 1'b0, 1'b0, 32'h0000_1234);
        issue("unchanged", 0, BASE + 32'h10, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0, 32'h1234_5678);

        // Reset in the middle of a store
        st0 = store_cnt;
        r0 = rsp_cnt0;
        r1 = rsp_cnt1;
        @(negedge clk);
        drive(1, 1'b1, BASE + 32'h20, 32'hAAAA_5555, 2'b10, 1'b0, 1'b1);
        n = 0;
        #1;
        while (!ready1 && n < 20) begin @(negedge clk); #1; n++; end
        @(posedge clk);
        @(negedge clk);
        drive(1, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0);
        check("rab_in_access", {31'h0, mem_we}, 32'h1);
        #1 rst = 1'b1;
        #1;
        check("rab_we_dropped", {31'h0, mem_we}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rab_no_store", store_cnt - st0, 0);
        check("rab_no_rsp", (rsp_cnt0 - r0) + (rsp_cnt1 - r1), 0);
        drive(0, 1'b1, BASE + 32'h20, 32'h0, 2'b10, 1'b0, 1'b0);
        drive(1, 1'b1, BASE + 32'h20, 32'h0, 2'b10, 1'b0, 1'b0);
        #1;
        check("rab_first_grant", {ready1, ready0}, 2'b01);
        @(negedge clk);
        drive(0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0);
        drive(1, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        issue("rab_not_written", 0, BASE + 32'h20, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter DMEM_BASE, default 32'h02000000, meaning the byte address of data memory location 0.
REQ-002 SHALL have parameter DMEM_BYTES, default 4096, meaning the size of the legal address window in bytes.
REQ-003 SHALL have port ip_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port ip_rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port ip_req_valid_n (n=0,1), input, 1 bit: requester n presents a request.
REQ-006 SHALL have port op_req_ready_n, output, 1 bit: request n accepted this cycle when ip_req_valid_n is also high.
REQ-007 SHALL have port ip_req_addr_n, input, 32 bits: byte address.
REQ-008 SHALL have port ip_req_wdata_n, input, 32 bits: store data, right-aligned.
REQ-009 SHALL have port ip_req_size_n, input, 2 bits: access size; 00 byte, 01 half, 10 word, 11 illegal.
REQ-010 SHALL have port ip_req_unsigned_n, input, 1 bit: load is zero-extended.
REQ-011 SHALL have port ip_req_we_n, input, 1 bit: 1 store, 0 load.
REQ-012 SHALL have port op_rsp_valid_n, output, 1 bit: one-cycle response strobe to requester n.
REQ-013 SHALL have port op_rsp_data_n, output, 32 bits: load result.
REQ-014 SHALL have port op_rsp_err_n, output, 1 bit: request was rejected.
REQ-015 SHALL have memory-side outputs op_mem_addr (32 bits), op_mem_store_data (32 bits), op_mem_bit_ctrl (2 bits), op_mem_sign_ctrl (1 bit) and op_mem_store_en (1 bit), and memory-side input ip_mem_read_data (32 bits), all connecting to the data memory ports of the same names.

Function
REQ-016 SHALL implement a two-state FSM: IDLE and ACCESS.
REQ-017 In IDLE, the winner SHALL be chosen from the requesters with valid high; with both valid, the winner SHALL be the port not granted last (round-robin).
REQ-018 op_req_ready_n SHALL be high only in IDLE, only for the winner, and SHALL be low for the other port.
REQ-019 On an accepted handshake, the request fields and the port index SHALL be latched, last-grant SHALL be updated, and the FSM SHALL go to ACCESS.
REQ-020 In ACCESS, the memory outputs SHALL be driven from the latched request, with op_mem_store_en = we AND NOT err; the FSM SHALL return to IDLE unconditionally at the next edge.
REQ-021 In IDLE, all memory outputs SHALL be 0.
REQ-022 err SHALL be set when any of the following holds: size=11; half access at an odd address; word access with addr[1:0]!=0; addr<DMEM_BASE; addr+bytes-1 >= DMEM_BASE+DMEM_BYTES. The comparison SHALL use 33-bit arithmetic, with no wrap-around.
REQ-023 At the ACCESS-to-IDLE edge, op_rsp_valid_n for the latched port SHALL be registered high for exactly one cycle; op_rsp_data_n SHALL equal ip_mem_read_data for an error-free load and 0 otherwise; op_rsp_err_n SHALL equal err.
REQ-024 Latency SHALL be 2 cycles from accept to response strobe; a new request SHALL be acceptable in the same cycle as a response strobe (throughput of 1 access per 2 cycles).
REQ-025 Response outputs of the non-addressed port SHALL stay 0.
REQ-026 A request whose valid drops before acceptance SHALL be ignored; the request fields SHALL be sampled only at the accept edge.

Reset
REQ-027 When ip_rst=1, the FSM SHALL be IDLE, last-grant SHALL be 1 (port 0 wins first), and all latches and all outputs SHALL be 0, regardless of the clock.
REQ-028 A reset during ACCESS SHALL abort the access with no store and no response strobe.

Structure
REQ-029 State encodings, the size codes (BYTE/HALF/WORD), DMEM_BASE and DMEM_BYTES defaults SHALL live in the shared macro file.
REQ-030 The round-robin pick SHALL be a sub-module rr_arb2 (inputs: two valids and last-grant; outputs: grant vector).

Verification
REQ-031 Port 0 stores word 32'h12345678 at 32'h02000010; port 1 then loads a word at 32'h02000010 -> store_en high for 1 cycle; rsp_data_1=32'h12345678, err=0, strobe 2 cycles after accept.
REQ-032 Both ports are valid every cycle for 4 grants after reset -> grant order 0,1,0,1; ready never high for both ports at once.
REQ-033 Port 0 stores byte 32'h08EF965D at 32'h02000000, then requests an LB and an LBU at 32'h02000000 -> LB returns 32'h0000005D and LBU returns 32'h0000005D; storing 32'hD9A438B8 gives LB 32'hFFFFFFB8 and LBU 32'h000000B8.
REQ-034 A half load at 32'h02000003, a word load at 32'h02000FFE, a store at 32'h01FFFFFC, and a request with size=11 -> err=1, data=0, store_en stays 0, and memory contents are unchanged.
REQ-035 Reset is asserted mid-ACCESS of a store -> no store_en pulse after reset, no rsp_valid, and the next request after reset goes to port 0.
